// File: rtl/sigmoid_plan_driver.sv
// sigmoid_plan_driver: buffers input samples, sequences one ap_ctrl_hs
// transaction per sample on the sigmoid_plan core, and returns each result
// on a valid/ready stream. Also exposes a transaction count, the latency of
// the last transaction and a sticky timeout flag for debug.
module sigmoid_plan_driver #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              core_ap_start,
  output logic [DATA_W-1:0] core_x,
  input  logic              core_ap_ready,
  input  logic              core_ap_done,
  input  logic [DATA_W-1:0] core_y,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  txn_count,
  output logic [CNT_W-1:0]  last_latency,
  output logic              timeout_err,
  output logic              busy
);

  localparam int               AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, HOLD} state_t;

  // Input buffer storage and bookkeeping
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              s_ready_q;

  // Sequencer state and registered outputs
  state_t            state_q;
  logic [DATA_W-1:0] core_x_q;
  logic              start_q;
  logic [DATA_W-1:0] m_data_q;
  logic              m_valid_q;
  logic [CNT_W-1:0]  txn_q;
  logic [CNT_W-1:0]  last_lat_q;
  logic [CNT_W-1:0]  lat_q;
  logic              timeout_q;

  logic             push, pop, capture, expired;
  logic [CNT_W-1:0] lat_inc;

  // s_ready is registered, so a push while full is refused even if a pop
  // happens in the same cycle.
  assign push = s_valid && s_ready_q;
  // A launch is the only consumer of the buffer head.
  assign pop  = (state_q == IDLE) && (count_q != '0) && !m_valid_q && !timeout_q;

  assign lat_inc = (lat_q == LAT_MAX) ? lat_q : lat_q + CNT_W'(1);

  // Done only counts while a transaction is in flight; in START the core
  // must also have taken its inputs in the same cycle.
  assign capture = ((state_q == START) && core_ap_ready && core_ap_done) ||
                   ((state_q == WAIT_DONE) && core_ap_done);
  assign expired = ((state_q == START) || (state_q == WAIT_DONE)) &&
                   !capture && (lat_q >= TIMEOUT_C);

  // Next buffer occupancy from this cycle's push/pop
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Sample storage: no reset, contents are don't-care while empty
  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr_q] <= s_data;
  end

  // Buffer pointers, occupancy and the registered not-full flag
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      s_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q   <= count_d;
      s_ready_q <= (count_d != DEPTH_C);
    end
  end

  // Transaction sequencer with result capture and latency/timeout tracking
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= IDLE;
      core_x_q   <= '0;
      start_q    <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      txn_q      <= '0;
      last_lat_q <= '0;
      lat_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q  <= START;
            core_x_q <= mem[rd_ptr_q];
            start_q  <= 1'b1;
            lat_q    <= CNT_W'(1);
          end
        end
        START: begin
          lat_q <= lat_inc;
          if (capture) begin
            state_q <= HOLD;
            start_q <= 1'b0;
          end else if (expired) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            timeout_q <= 1'b1;
          end else if (core_ap_ready) begin
            state_q <= WAIT_DONE;
            start_q <= 1'b0;
          end
        end
        WAIT_DONE: begin
          lat_q <= lat_inc;
          if (capture) begin
            state_q <= HOLD;
          end else if (expired) begin
            state_q   <= IDLE;
            timeout_q <= 1'b1;
          end
        end
        HOLD: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (capture) begin
        m_data_q   <= core_y;
        m_valid_q  <= 1'b1;
        txn_q      <= txn_q + CNT_W'(1);
        last_lat_q <= lat_q;
      end
    end
  end

  assign s_ready       = s_ready_q;
  assign core_ap_start = start_q;
  assign core_x        = core_x_q;
  assign m_data        = m_data_q;
  assign m_valid       = m_valid_q;
  assign txn_count     = txn_q;
  assign last_latency  = last_lat_q;
  assign timeout_err   = timeout_q;
  assign busy          = (state_q != IDLE) || (count_q != '0);

endmodule
